// File: rtl/nwc_ntt_agu.sv
// Address and twiddle generator for an in-place N-point negacyclic forward NTT
// (Cooley-Tukey, one radix-2 butterfly per cycle, write-back delayed to match the datapath).
module nwc_ntt_agu #(
   parameter int N      = 64,
   parameter int LOG_N  = 6,
   parameter int RD_LAT = 1,
   parameter int BU_LAT = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(LOG_N+1)-1:0]   stage_idx,
   output logic                         rd_en,
   output logic [LOG_N-1:0]             rd_addr_up,
   output logic [LOG_N-1:0]             rd_addr_down,
   output logic [LOG_N-1:0]             tw_addr,
   output logic                         wr_en,
   output logic [LOG_N-1:0]             wr_addr_up,
   output logic [LOG_N-1:0]             wr_addr_down
);

   localparam int PIPE_LAT = RD_LAT + BU_LAT;
   localparam int SW       = $clog2(LOG_N + 1);
   localparam int DW       = $clog2(PIPE_LAT + 1);
   localparam logic [LOG_N-1:0] HALF = LOG_N'(N / 2);
   localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t           state;
   logic [LOG_N-1:0] t_reg;
   logic [LOG_N-1:0] m_reg;
   logic [LOG_N-1:0] j_reg;
   logic [LOG_N-1:0] cnt_reg;
   logic [DW-1:0]    drain_reg;

   logic             last_in_group;
   logic             last_in_stage;
   logic [LOG_N-1:0] up_next;

   // At the end of a group the next up index skips over the group's down half.
   always_comb begin
      last_in_group = (j_reg == t_reg - ONE);
      last_in_stage = (cnt_reg == HALF - ONE);
      up_next       = last_in_group ? (rd_addr_up + t_reg + ONE) : (rd_addr_up + ONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         stage_idx    <= '0;
         rd_en        <= 1'b0;
         rd_addr_up   <= '0;
         rd_addr_down <= '0;
         tw_addr      <= '0;
         t_reg        <= '0;
         m_reg        <= '0;
         j_reg        <= '0;
         cnt_reg      <= '0;
         drain_reg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state        <= ISSUE;
                  busy         <= 1'b1;
                  stage_idx    <= '0;
                  rd_en        <= 1'b1;
                  t_reg        <= HALF;
                  m_reg        <= ONE;
                  j_reg        <= '0;
                  cnt_reg      <= '0;
                  rd_addr_up   <= '0;
                  rd_addr_down <= HALF;
                  tw_addr      <= ONE;
               end
            end
            ISSUE: begin
               if (last_in_stage) begin
                  state        <= DRAIN;
                  rd_en        <= 1'b0;
                  rd_addr_up   <= '0;
                  rd_addr_down <= '0;
                  tw_addr      <= '0;
                  drain_reg    <= '0;
               end else begin
                  cnt_reg      <= cnt_reg + ONE;
                  j_reg        <= last_in_group ? '0 : (j_reg + ONE);
                  rd_addr_up   <= up_next;
                  rd_addr_down <= up_next + t_reg;
                  if (last_in_group)
                     tw_addr <= tw_addr + ONE;
               end
            end
            DRAIN: begin
               // Hold off the next stage until its last write-back has left the pipe.
               if (drain_reg == DW'(PIPE_LAT - 1)) begin
                  if (stage_idx == SW'(LOG_N - 1)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state        <= ISSUE;
                     rd_en        <= 1'b1;
                     stage_idx    <= stage_idx + SW'(1);
                     t_reg        <= t_reg >> 1;
                     m_reg        <= m_reg << 1;
                     j_reg        <= '0;
                     cnt_reg      <= '0;
                     rd_addr_up   <= '0;
                     rd_addr_down <= t_reg >> 1;
                     tw_addr      <= m_reg << 1;
                  end
               end else begin
                  drain_reg <= drain_reg + DW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic             en_dly [PIPE_LAT];
   logic [LOG_N-1:0] up_dly [PIPE_LAT];
   logic [LOG_N-1:0] dn_dly [PIPE_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < PIPE_LAT; k++) begin
            en_dly[k] <= 1'b0;
            up_dly[k] <= '0;
            dn_dly[k] <= '0;
         end
      end else begin
         en_dly[0] <= rd_en;
         up_dly[0] <= rd_addr_up;
         dn_dly[0] <= rd_addr_down;
         for (int k = 1; k < PIPE_LAT; k++) begin
            en_dly[k] <= en_dly[k-1];
            up_dly[k] <= up_dly[k-1];
            dn_dly[k] <= dn_dly[k-1];
         end
      end
   end

   assign wr_en        = en_dly[PIPE_LAT-1];
   assign wr_addr_up   = up_dly[PIPE_LAT-1];
   assign wr_addr_down = dn_dly[PIPE_LAT-1];

endmodule

// File: tb/tb_nwc_ntt_agu.sv
// Bench for nwc_ntt_agu: per-cycle comparison against a loop-level schedule model,
// literal pins on key cycles, ignored-start and mid-run reset cases, then random traffic.
module tb_nwc_ntt_agu;

   localparam int N = 64, LOG_N = 6, RD_LAT = 1, BU_LAT = 2;
   localparam int P = RD_LAT + BU_LAT;
   localparam int STAGE_LEN = N / 2 + P;
   localparam int MAXC = 3000;
   localparam int S = 30;
   localparam int B = S + 212;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic       busy, done, rd_en, wr_en;
   logic [2:0] stage_idx;
   logic [5:0] rd_addr_up, rd_addr_down, tw_addr, wr_addr_up, wr_addr_down;

   nwc_ntt_agu #(.N(N), .LOG_N(LOG_N), .RD_LAT(RD_LAT), .BU_LAT(BU_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .stage_idx(stage_idx), .rd_en(rd_en), .rd_addr_up(rd_addr_up),
      .rd_addr_down(rd_addr_down), .tw_addr(tw_addr), .wr_en(wr_en),
      .wr_addr_up(wr_addr_up), .wr_addr_down(wr_addr_down));

   always #5 clk = ~clk;

   int cyc = -1;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, passes = 0;

   // Expected behaviour per cycle, built from the stage/group/butterfly loops.
   bit         e_busy[MAXC], e_done[MAXC], e_rd[MAXC], e_wr[MAXC], e_st_v[MAXC], e_zero[MAXC];
   logic [5:0] e_up[MAXC], e_dn[MAXC], e_tw[MAXC], e_wu[MAXC], e_wd[MAXC];
   logic [2:0] e_st[MAXC];
   int         done_cycle = -1;

   task automatic model_reset(input int r);
      for (int c = r + 1; c < MAXC; c++) begin
         e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_wr[c] = 0;
         e_st_v[c] = 1; e_st[c] = 0; e_zero[c] = 1;
      end
      done_cycle = r;
   endtask

   task automatic model_start(input int k);
      if (k > done_cycle) begin
         $display("run start sampled at cycle %0d", k);
         for (int c = k + 1; c < MAXC; c++) begin
            e_zero[c] = 0; e_st_v[c] = 0;
         end
         for (int s = 0; s < LOG_N; s++) begin
            int m, t;
            m = 1 << s;
            t = N >> (s + 1);
            for (int i = 0; i < m; i++) begin
               for (int j = 0; j < t; j++) begin
                  int c, up;
                  c  = k + 1 + s * STAGE_LEN + i * t + j;
                  up = 2 * i * t + j;
                  if (c < MAXC) begin
                     e_rd[c] = 1; e_up[c] = 6'(up); e_dn[c] = 6'(up + t); e_tw[c] = 6'(m + i);
                     e_st_v[c] = 1; e_st[c] = 3'(s);
                  end
                  if (c + P < MAXC) begin
                     e_wr[c+P] = 1; e_wu[c+P] = 6'(up); e_wd[c+P] = 6'(up + t);
                  end
               end
            end
         end
         done_cycle = k + 1 + LOG_N * STAGE_LEN;
         for (int c = k + 1; c < done_cycle && c < MAXC; c++) e_busy[c] = 1;
         if (done_cycle < MAXC) e_done[done_cycle] = 1;
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MAXC) begin
         bit ok;
         ok = (busy === e_busy[cyc]) && (done === e_done[cyc]) &&
              (rd_en === e_rd[cyc]) && (wr_en === e_wr[cyc]);
         if (e_rd[cyc])
            ok = ok && (rd_addr_up === e_up[cyc]) && (rd_addr_down === e_dn[cyc]) && (tw_addr === e_tw[cyc]);
         if (e_wr[cyc])
            ok = ok && (wr_addr_up === e_wu[cyc]) && (wr_addr_down === e_wd[cyc]);
         if (e_st_v[cyc])
            ok = ok && (stage_idx === e_st[cyc]);
         if (e_zero[cyc])
            ok = ok && (rd_addr_up === 6'd0) && (rd_addr_down === 6'd0) && (tw_addr === 6'd0) &&
                 (wr_addr_up === 6'd0) && (wr_addr_down === 6'd0);
         checks++;
         if (ok) passes++;
         else $display("FAIL cycle %0d outputs: got busy=%b done=%b rd=%b(%0d,%0d,%0d) st=%0d wr=%b(%0d,%0d) expected busy=%b done=%b rd=%b(%0d,%0d,%0d) st=%0d wr=%b(%0d,%0d)",
                       cyc, busy, done, rd_en, rd_addr_up, rd_addr_down, tw_addr, stage_idx, wr_en, wr_addr_up, wr_addr_down,
                       e_busy[cyc], e_done[cyc], e_rd[cyc], e_up[cyc], e_dn[cyc], e_tw[cyc], e_st[cyc], e_wr[cyc], e_wu[cyc], e_wd[cyc]);
      end
   end

   // Tally of the first full run: issue/write counts and per-stage write coverage.
   int rd_cnt = 0, wr_cnt = 0;
   int wcnt[LOG_N][N];
   always @(negedge clk) begin
      if (cyc >= S + 1 && cyc <= S + 211) begin
         if (rd_en === 1'b1) rd_cnt++;
         if (wr_en === 1'b1) begin
            wr_cnt++;
            if (cyc >= S + 4 && (cyc - S - 4) / STAGE_LEN < LOG_N) begin
               wcnt[(cyc - S - 4) / STAGE_LEN][wr_addr_up]++;
               wcnt[(cyc - S - 4) / STAGE_LEN][wr_addr_down]++;
            end
         end
      end
   end

   task automatic go(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   function automatic int tup(input logic en, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
      return int'(en) * 1000000 + int'(a) * 10000 + int'(b) * 100 + int'(c);
   endfunction

   function automatic int rd_tup();
      return tup(rd_en, rd_addr_up, rd_addr_down, tw_addr);
   endfunction

   function automatic int any_out();
      return int'(busy | done | rd_en | wr_en | (|stage_idx) | (|rd_addr_up) | (|rd_addr_down) |
                  (|tw_addr) | (|wr_addr_up) | (|wr_addr_down));
   endfunction

   task automatic pulse_start(input int c);
      go(c); start = 1'b1; model_start(c);
      go(c + 1); start = 1'b0;
   endtask

   initial begin
      model_reset(0);
      go(2); rst = 1'b0;

      go(21); chk("idle outputs", any_out(), 0);

      pulse_start(S);
      chk("s0 issue1", rd_tup(), 1003201);
      chk("s0 stage_idx", int'(stage_idx), 0);
      go(S + 2);  chk("s0 issue2", rd_tup(), 1013301);
      go(S + 3);  chk("s0 issue3", rd_tup(), 1023401);
      go(S + 4);  chk("s0 first write", tup(wr_en, wr_addr_up, wr_addr_down, 6'd0), 1003200);
      go(S + 32); chk("s0 issue32", rd_tup(), 1316301);
      go(S + 33); chk("s0 drain rd_en", int'(rd_en), 0);
      go(S + 35); chk("s0 last write", tup(wr_en, wr_addr_up, wr_addr_down, 6'd0), 1316300);
      go(S + 36); chk("s1 issue1", rd_tup(), 1001602);
      chk("s1 stage_idx", int'(stage_idx), 1);
      pulse_start(S + 50);
      go(S + 52); chk("s1 issue17", rd_tup(), 1324803);
      go(S + 176); chk("s5 issue1", rd_tup(), 1000132);
      go(S + 207); chk("s5 issue32", rd_tup(), 1626363);
      go(S + 210); chk("busy/done before end", int'(busy) * 10 + int'(done), 10);
      go(S + 211); chk("done cycle", int'(busy) * 10 + int'(done), 1);
      start = 1'b1; model_start(S + 211);
      go(S + 212); start = 1'b0;
      chk("after done", int'(busy) * 10 + int'(done), 0);
      chk("rd_en count", rd_cnt, 192);
      chk("wr_en count", wr_cnt, 192);
      for (int s = 0; s < LOG_N; s++) begin
         int bad;
         bad = 0;
         for (int a = 0; a < N; a++) if (wcnt[s][a] != 1) bad++;
         chk($sformatf("stage %0d write coverage", s), bad, 0);
      end

      pulse_start(B);
      chk("rerun issue1", rd_tup(), 1003201);

      go(B + 100); rst = 1'b1; model_reset(B + 100);
      $display("reset asserted at cycle %0d", B + 100);
      go(B + 101); rst = 1'b0;
      chk("post-reset outputs", any_out(), 0);
      pulse_start(B + 105);
      chk("restart issue1", rd_tup(), 1003201);
      go(B + 105 + 211); chk("restart done", int'(done), 1);

      for (int c = 600; c < 2600; c++) begin
         bit r, s;
         go(c);
         r = ($urandom_range(0, 399) == 0);
         s = !r && ($urandom_range(0, 24) == 0);
         rst = r;
         start = s;
         if (r) begin
            model_reset(c);
            $display("reset asserted at cycle %0d", c);
         end else if (s) begin
            model_start(c);
         end
      end
      go(2600); rst = 1'b0; start = 1'b0;
      go(2650);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
